fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 6 +
 rtl/if_id_reg.sv | 31 +++
 rtl/fetch_stage.sv | 66 ++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, WAIT, KILL} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr_q,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_plus4_q,
  output logic            valid_q
);
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!stall) begin
      instr_q    <= load ? instr : NOP_INSTR;
      pc_q       <= load ? pc : '0;
      pc_plus4_q <= load ? pc_plus4 : '0;
      valid_q    <= load;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch FSM, skid buffer and IF/ID register
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchWaitF
);
  fetch_state_t state, state_n;
  logic [XLEN-1:0] pcf, pcf4, buf_instr;
  logic buf_valid, rsp, deliver, capture;
  assign pcf4 = pcf + 32'd4;
  assign FetchWaitF = rst && state != IDLE;
  always_comb begin
    rsp = state == WAIT && imem_rvalid && !PCSrcE;
    deliver = !PCSrcE && !StallF && !StallD && (buf_valid || rsp);
    capture = rsp && (StallD || StallF);
    imem_req = rst && !PCSrcE && (state == IDLE ? !buf_valid : rsp && deliver);
    imem_addr = state == WAIT ? pcf4 : pcf;
    state_n = PCSrcE ? (state != IDLE && !imem_rvalid ? KILL : IDLE)
            : state == KILL ? (imem_rvalid ? IDLE : KILL)
            : (state == IDLE || imem_rvalid) ? (imem_req ? WAIT : IDLE) : WAIT;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pcf       <= RESET_PC;
      buf_valid <= 1'b0;
    end else begin
      state     <= state_n;
      pcf       <= PCSrcE ? PCTargetE : deliver ? pcf4 : pcf;
      buf_valid <= !PCSrcE && (capture || (buf_valid && !deliver));
    end
  end
  always_ff @(posedge clk)
    if (capture) buf_instr <= imem_rdata;
  if_id_reg u_if_id (
    .clk       (clk),
    .rst       (rst),
    .stall     (StallD),
    .flush     (FlushD),
    .load      (deliver),
    .instr     (buf_valid ? buf_instr : imem_rdata),
    .pc        (pcf),
    .pc_plus4  (pcf4),
    .instr_q   (InstrD),
    .pc_q      (PCD),
    .pc_plus4_q(PCPlus4D),
    .valid_q   (ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, directed corner cases and random stream scoreboard for fetch_stage
module tb_fetch_stage;
  import riscv_pkg::*;
  localparam logic [31:0] RST_PC = 32'h0;
  logic clk = 0, rst, StallF, StallD, FlushD, PCSrcE, imem_rvalid, imem_req, ValidD, FetchWaitF;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  always #5 clk = ~clk;
  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchWaitF(FetchWaitF)
  );
  typedef struct {logic [31:0] addr; int due;} req_t;
  typedef struct {
    logic sd, sf, fd, ps; logic [31:0] tg;
    logic req; logic [31:0] addr; logic v; logic [31:0] pcd, ins;
  } vec_t;
  req_t q[$];
  vec_t tv[12];
  int cyc = 0, errors = 0, checks = 0, lat_lo = 1, lat_hi = 1, nvalid = 0;
  logic [31:0] exp_pc = RST_PC, s_addr;
  logic s_req, s_fw;
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a == 32'h0 ? 32'h0010_0093 : a == 32'h4 ? 32'h0020_0113 : (a * 32'd3) ^ 32'h1234_5677;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic step(input logic r, sd, sf, fd, ps, input logic [31:0] tg);
    logic [31:0] pi, pp, p4;
    logic pv;
    @(negedge clk);
    rst = r; StallD = sd; StallF = sf; FlushD = fd; PCSrcE = ps; PCTargetE = tg;
    if (!r) q.delete();
    imem_rvalid = r && q.size() > 0 && q[0].due <= cyc;
    imem_rdata = imem_rvalid ? memw(q[0].addr) : $urandom;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_fw = FetchWaitF;
    if (imem_rvalid) void'(q.pop_front());
    if (!r) begin
      chk("req_in_reset", {31'b0, s_req}, 0);
      chk("wait_in_reset", {31'b0, s_fw}, 0);
    end
    if (s_req) begin
      chk("one_outstanding", 32'(q.size()), 0);
      q.push_back('{s_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
    end
    pi = InstrD; pp = PCD; p4 = PCPlus4D; pv = ValidD;
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      chk("rst_valid", {31'b0, ValidD}, 0);
      chk("rst_instr", InstrD, NOP_INSTR);
      chk("rst_pcd", PCD, 0);
      chk("rst_pc4", PCPlus4D, 0);
      exp_pc = RST_PC;
    end else if (fd) begin
      chk("flush_valid", {31'b0, ValidD}, 0);
      chk("flush_instr", InstrD, NOP_INSTR);
    end else if (sd) begin
      chk("hold_instr", InstrD, pi);
      chk("hold_pcd", PCD, pp);
      chk("hold_pc4", PCPlus4D, p4);
      chk("hold_valid", {31'b0, ValidD}, {31'b0, pv});
    end else if (ValidD) begin
      chk("pcd_order", PCD, exp_pc);
      chk("instr_data", InstrD, memw(PCD));
      chk("pc_plus4", PCPlus4D, PCD + 32'd4);
      exp_pc += 32'd4;
      nvalid++;
    end else begin
      chk("bubble_instr", InstrD, NOP_INSTR);
      chk("bubble_pcd", PCD, 0);
    end
    if (r && ps) exp_pc = tg;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int last_req, nfw, gap, n0;
    logic found;
    rst = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    imem_rvalid = 0; imem_rdata = 0;
    tv[0]  = '{0, 0, 0, 0, 0,       1, 32'h0,   0, 32'h0,   NOP_INSTR};
    tv[1]  = '{0, 0, 0, 0, 0,       1, 32'h4,   1, 32'h0,   32'h0010_0093};
    tv[2]  = '{0, 0, 0, 0, 0,       1, 32'h8,   1, 32'h4,   32'h0020_0113};
    tv[3]  = '{0, 0, 0, 0, 0,       1, 32'hC,   1, 32'h8,   memw(32'h8)};
    tv[4]  = '{1, 1, 0, 0, 0,       0, 32'h0,   1, 32'h8,   memw(32'h8)};
    tv[5]  = '{1, 1, 0, 0, 0,       0, 32'h0,   1, 32'h8,   memw(32'h8)};
    tv[6]  = '{0, 0, 0, 0, 0,       0, 32'h0,   1, 32'hC,   memw(32'hC)};
    tv[7]  = '{0, 0, 0, 0, 0,       1, 32'h10,  0, 32'h0,   NOP_INSTR};
    tv[8]  = '{0, 0, 1, 1, 32'h100, 0, 32'h0,   0, 32'h0,   NOP_INSTR};
    tv[9]  = '{0, 0, 0, 0, 0,       1, 32'h100, 0, 32'h0,   NOP_INSTR};
    tv[10] = '{0, 0, 0, 0, 0,       1, 32'h104, 1, 32'h100, memw(32'h100)};
    tv[11] = '{0, 0, 0, 0, 0,       1, 32'h108, 1, 32'h104, memw(32'h104)};
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, tv[i].sd, tv[i].sf, tv[i].fd, tv[i].ps, tv[i].tg);
      chk($sformatf("tv%0d_req", i), {31'b0, s_req}, {31'b0, tv[i].req});
      if (tv[i].req) chk($sformatf("tv%0d_addr", i), s_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), {31'b0, ValidD}, {31'b0, tv[i].v});
      chk($sformatf("tv%0d_pcd", i), PCD, tv[i].pcd);
      chk($sformatf("tv%0d_instr", i), InstrD, tv[i].ins);
    end
    lat_lo = 3; lat_hi = 3;
    step(0, 0, 0, 0, 0, 0);
    last_req = -1; nfw = 0; gap = -1;
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (s_req) begin
        if (last_req >= 0) chk("req_spacing", 32'(i - last_req), 3);
        last_req = i;
      end
      nfw += int'(s_fw);
      if (ValidD) begin
        if (gap >= 0) chk("bubbles", 32'(gap), 2);
        gap = 0;
      end else if (gap >= 0) gap++;
    end
    chk("fetchwait_cycles", 32'(nfw), 12);
    step(1, 0, 0, 1, 1, 32'h200);
    chk("redirect_no_req", {31'b0, s_req}, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("kill_wait", {31'b0, s_fw}, 1);
    chk("kill_no_req", {31'b0, s_req}, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (s_req) begin
        chk("redirect_addr", s_addr, 32'h200);
        found = 1;
      end
    end
    chk("redirect_req_seen", {31'b0, found}, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (ValidD) begin
        chk("redirect_pcd", PCD, 32'h200);
        found = 1;
      end
    end
    chk("redirect_valid_seen", {31'b0, found}, 1);
    lat_lo = 1; lat_hi = 1;
    step(1, 0, 0, 1, 1, 32'hFFFF_FFFC);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (ValidD && PCD == 32'hFFFF_FFFC) begin
        chk("wrap_pc4", PCPlus4D, 32'h0);
        chk("wrap_req", {31'b0, s_req}, 1);
        chk("wrap_next_addr", s_addr, 32'h0);
        found = 1;
      end
    end
    chk("wrap_seen", {31'b0, found}, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap_next_valid", {31'b0, ValidD}, 1);
    chk("wrap_next_pcd", PCD, 32'h0);
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 0, 0, 0, 0);
      found = s_fw;
    end
    chk("mid_wait_reached", {31'b0, found}, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("reset_fetchwait", {31'b0, FetchWaitF}, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("post_reset_req", {31'b0, s_req}, 1);
    chk("post_reset_addr", s_addr, RST_PC);
    lat_lo = 1; lat_hi = 4;
    n0 = nvalid;
    for (int i = 0; i < 3000; i++) begin
      logic ps;
      logic [31:0] tg;
      ps = $urandom_range(0, 24) == 0;
      tg = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2)
                                     : 32'($urandom_range(0, 255)) << 2;
      step(1, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, ps, ps, tg);
    end
    chk("random_progress", {31'b0, (nvalid - n0) > 100}, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
